// File: rtl/secuenciador_filtro_pkg.sv
// ============================================================================
// Module      : secuenciador_filtro_pkg
// Description : Shared constants for the band-filter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package secuenciador_filtro_pkg;

    localparam int c_WIDTH_DEF  = 22;
    localparam int c_SETTLE_DEF = 2;
    localparam int c_CNT_W      = 4;

    localparam logic [1:0] BANDA_ALTAS  = 2'b00;
    localparam logic [1:0] BANDA_MEDIAS = 2'b01;
    localparam logic [1:0] BANDA_BAJAS  = 2'b10;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEL  = 2'd1;
    localparam logic [1:0] c_ST_CAP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/secuenciador_filtro_contador.sv
// ============================================================================
// Module      : contador_asentamiento
// Description : Settle down-counter; flags when the last settle cycle is due.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_asentamiento
    import secuenciador_filtro_pkg::*;
#(
    parameter int SETTLE = c_SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_es_uno
);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_CNT_W'(SETTLE);
        end else if (i_dec) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_es_uno = (r_cnt == c_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/secuenciador_filtro.sv
// ============================================================================
// Module      : secuenciador_filtro
// Description : Steps one ADC sample through the altas/medias/bajas filter
//               bands and holds each band result. Optional macro
//               SECUENCIADOR_OVERRUN_EN enables the sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secuenciador_filtro
    import secuenciador_filtro_pkg::*;
#(
    parameter int Width  = c_WIDTH_DEF,
    parameter int SETTLE = c_SETTLE_DEF
) (
    input  logic             clk150kHz,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [Width-1:0] sample_in,
    output logic             sample_ready,
    output logic [Width-1:0] uk,
    output logic [1:0]       Sel_Muxes,
    output logic             enable1,
    output logic             enable2,
    output logic             enable3,
    input  logic [Width-1:0] y_filtro,
    output logic [Width-1:0] y_altas,
    output logic [Width-1:0] y_medias,
    output logic [Width-1:0] y_bajas,
    output logic             out_valid,
    output logic             overrun
);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [1:0] r_banda;
    logic       w_load;
    logic       w_dec;
    logic       w_es_uno;

    contador_asentamiento #(
        .SETTLE (SETTLE)
    ) u_contador (
        .clk      (clk150kHz),
        .rst_n    (reset),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_es_uno (w_es_uno)
    );

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_banda  <= BANDA_ALTAS;
            uk       <= '0;
            y_altas  <= '0;
            y_medias <= '0;
            y_bajas  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_IDLE && sample_valid) begin
                uk      <= sample_in;
                r_banda <= BANDA_ALTAS;
            end
            if (r_state == c_ST_CAP) begin
                case (r_banda)
                    BANDA_ALTAS:  y_altas  <= y_filtro;
                    BANDA_MEDIAS: y_medias <= y_filtro;
                    default:      y_bajas  <= y_filtro;
                endcase
                if (r_banda != BANDA_BAJAS) begin
                    r_banda <= r_banda + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        sample_ready = 1'b0;
        Sel_Muxes    = BANDA_ALTAS;
        enable1      = 1'b0;
        enable2      = 1'b0;
        enable3      = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    w_next = c_ST_SEL;
                    w_load = 1'b1;
                end
            end
            c_ST_SEL: begin
                Sel_Muxes = r_banda;
                w_dec     = 1'b1;
                if (w_es_uno) begin
                    w_next = c_ST_CAP;
                end
            end
            c_ST_CAP: begin
                Sel_Muxes = r_banda;
                enable1   = (r_banda == BANDA_ALTAS);
                enable2   = (r_banda == BANDA_MEDIAS);
                enable3   = (r_banda == BANDA_BAJAS);
                if (r_banda == BANDA_BAJAS) begin
                    w_next = c_ST_DONE;
                end else begin
                    w_next = c_ST_SEL;
                    w_load = 1'b1;
                end
            end
            default: begin
                out_valid = 1'b1;
                w_next    = c_ST_IDLE;
            end
        endcase
    end

`ifdef SECUENCIADOR_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (sample_valid && r_state != c_ST_IDLE) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_filtro.sv
// ============================================================================
// Module      : tb_secuenciador_filtro
// Description : Bench for secuenciador_filtro, SETTLE=2 and SETTLE=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_secuenciador_filtro;

    localparam int W = 22;
`ifdef SECUENCIADOR_OVERRUN_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          sv;
    logic [1:0][W-1:0]   si, ukv, yf, ya, ym, yb, base;
    logic [1:0][1:0]     sel;
    logic [1:0]          rdy, e1, e2, e3, ovl, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] y_model [2][3];
    bit           ov_model [2];

    always #5 clk = ~clk;

    // Filter stand-in: band code selects a fixed offset on top of a per-sample base
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            yf[i] = base[i] + {12'd0, sel[i], 8'd0} + 22'd1;
        end
    end

    secuenciador_filtro #(.Width(W), .SETTLE(2)) dut_a (
        .clk150kHz(clk), .reset(rst_n), .sample_valid(sv[0]), .sample_in(si[0]),
        .sample_ready(rdy[0]), .uk(ukv[0]), .Sel_Muxes(sel[0]),
        .enable1(e1[0]), .enable2(e2[0]), .enable3(e3[0]), .y_filtro(yf[0]),
        .y_altas(ya[0]), .y_medias(ym[0]), .y_bajas(yb[0]),
        .out_valid(ovl[0]), .overrun(ovf[0])
    );

    secuenciador_filtro #(.Width(W), .SETTLE(1)) dut_b (
        .clk150kHz(clk), .reset(rst_n), .sample_valid(sv[1]), .sample_in(si[1]),
        .sample_ready(rdy[1]), .uk(ukv[1]), .Sel_Muxes(sel[1]),
        .enable1(e1[1]), .enable2(e2[1]), .enable3(e3[1]), .y_filtro(yf[1]),
        .y_altas(ya[1]), .y_medias(ym[1]), .y_bajas(yb[1]),
        .out_valid(ovl[1]), .overrun(ovf[1])
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input int d);
        chk($sformatf("rst_uk%0d", d), ukv[d], '0);
        chk($sformatf("rst_sel%0d", d), W'(sel[d]), '0);
        chk($sformatf("rst_en%0d", d), W'({e1[d], e2[d], e3[d]}), '0);
        chk($sformatf("rst_ya%0d", d), ya[d], '0);
        chk($sformatf("rst_ym%0d", d), ym[d], '0);
        chk($sformatf("rst_yb%0d", d), yb[d], '0);
        chk($sformatf("rst_ov%0d", d), W'(ovl[d]), '0);
        chk($sformatf("rst_ovr%0d", d), W'(ovf[d]), '0);
    endtask

    // One accepted sample; cycle 0 is the accept cycle, checks run every cycle up to the next IDLE.
    task automatic run_seq(input int d, input logic [W-1:0] samp, input logic [W-1:0] b,
                           input bit hold_valid);
        int s;
        int last;
        int cap;
        int exp_sel;
        logic [W-1:0] yn [3];
        s    = (d == 0) ? 2 : 1;
        last = 3 * (s + 1) + 1;
        for (int k = 0; k < 3; k++) yn[k] = b + W'(k * 'h100) + W'(1);
        chk("accept_ready", W'(rdy[d]), W'(1));
        sv[d] = 1'b1; si[d] = samp; base[d] = b;
        step();
        for (int c = 1; c <= last; c++) begin
            cap     = (c % (s + 1) == 0 && c <= 3 * (s + 1)) ? c / (s + 1) - 1 : -1;
            exp_sel = (c <= 3 * (s + 1)) ? (c - 1) / (s + 1) : 0;
            chk($sformatf("en1_c%0d", c), W'(e1[d]), W'(cap == 0));
            chk($sformatf("en2_c%0d", c), W'(e2[d]), W'(cap == 1));
            chk($sformatf("en3_c%0d", c), W'(e3[d]), W'(cap == 2));
            chk($sformatf("sel_c%0d", c), W'(sel[d]), W'(exp_sel));
            chk($sformatf("outv_c%0d", c), W'(ovl[d]), W'(c == last));
            chk($sformatf("ready_c%0d", c), W'(rdy[d]), W'(0));
            chk($sformatf("uk_c%0d", c), ukv[d], samp);
            chk($sformatf("ovr_c%0d", c), W'(ovf[d]), W'(ov_model[d]));
            chk($sformatf("ya_c%0d", c), ya[d], (c > 1 * (s + 1)) ? yn[0] : y_model[d][0]);
            chk($sformatf("ym_c%0d", c), ym[d], (c > 2 * (s + 1)) ? yn[1] : y_model[d][1]);
            chk($sformatf("yb_c%0d", c), yb[d], (c > 3 * (s + 1)) ? yn[2] : y_model[d][2]);
            sv[d] = hold_valid ? 1'b1 : ($urandom_range(0, 3) == 0);
            si[d] = W'($urandom);
            if (sv[d] && OV_EN) ov_model[d] = 1'b1;
            step();
        end
        for (int k = 0; k < 3; k++) y_model[d][k] = yn[k];
        chk("idle_ready", W'(rdy[d]), W'(1));
        chk("idle_sel", W'(sel[d]), W'(0));
        chk("idle_uk", ukv[d], samp);
        chk("idle_ovr", W'(ovf[d]), W'(ov_model[d]));
        chk("idle_ya", ya[d], yn[0]);
        chk("idle_ym", ym[d], yn[1]);
        chk("idle_yb", yb[d], yn[2]);
        sv[d] = 1'b0;
    endtask

    task automatic gap(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("gap_ready", W'(rdy[d]), W'(1));
            chk("gap_outv", W'(ovl[d]), W'(0));
        end
    endtask

    initial begin
        sv = '0; si = '0; base = '0;
        for (int d = 0; d < 2; d++) begin
            ov_model[d] = 1'b0;
            for (int k = 0; k < 3; k++) y_model[d][k] = '0;
        end

        repeat (3) step();
        chk_zero(0);
        chk_zero(1);
        rst_n = 1'b1;
        chk("post_rst_ready", W'(rdy[0]), W'(1));
        step();

        // Directed single sample, base 0 gives 0x000001/0x000101/0x000201
        run_seq(0, 22'h001000, '0, 1'b0);
        gap(0, 1);

        for (int i = 0; i < 4; i++) begin
            run_seq(0, W'($urandom), W'($urandom), 1'b0);
            gap(0, $urandom_range(0, 2));
        end

        // Continuous sample_valid: accepts land in cycle 0 and cycle 11
        run_seq(0, W'($urandom), W'($urandom), 1'b1);
        run_seq(0, W'($urandom), W'($urandom), 1'b0);
        gap(0, 1);

        run_seq(1, 22'h001000, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_seq(1, W'($urandom), W'($urandom), 1'b0);
            gap(1, $urandom_range(0, 2));
        end

        // Reset asserted in cycle 5 of a sequence
        chk("mid_accept_ready", W'(rdy[0]), W'(1));
        sv[0] = 1'b1; si[0] = 22'h2abcde; base[0] = 22'h012345;
        step();
        sv[0] = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_outv", W'(ovl[0]), W'(0));
        end
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ov_model[d] = 1'b0;
            for (int k = 0; k < 3; k++) y_model[d][k] = '0;
        end
        chk("release_ready", W'(rdy[0]), W'(1));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("release_outv", W'(ovl[0]), W'(0));
            chk("release_ready_hold", W'(rdy[0]), W'(1));
        end

        run_seq(0, W'($urandom), W'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
